// File: rtl/indicator_pkg.sv
// Shared constants and FSM encoding for the 7-segment indicator path.
// BCD_BLANK doubles as the indicator's index of its all-off segment pattern.
package indicator_pkg;

    localparam logic [3:0]  BCD_BLANK   = 4'd10;
    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned MAX_DISPLAY = 9999;
    localparam int unsigned BCD_W       = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        BLANK
    } conv_state_t;

    // Nibbles NUM_DIGITS-1..1 become blank while every higher nibble is blank; nibble 0 always shows.
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        logic             leading;
        r       = bcd;
        leading = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (leading && r[4*i +: 4] == 4'd0) begin
                r[4*i +: 4] = BCD_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd_digits_if.sv
// Handshake and result bundle between the upstream value source and the BCD converter.
interface bin_to_bcd_digits_if
    import indicator_pkg::*;
#(
    parameter int unsigned WIDTH = 14
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] value;
    logic             out_valid;
    logic [BCD_W-1:0] digits_bcd;
    logic             overflow;

    modport master (
        output in_valid, value,
        input  in_ready, out_valid, digits_bcd, overflow
    );

    modport slave (
        input  in_valid, value,
        output in_ready, out_valid, digits_bcd, overflow
    );
endinterface

// File: rtl/bin_to_bcd_digits_bcd_add3.sv
// Double-dabble digit correction: nibbles of 5 or more get +3 before each shift.
module bcd_add3 (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);
    assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
endmodule

// File: rtl/bin_to_bcd_digits.sv
// Sequential shift-and-add-3 binary-to-BCD converter with optional leading-zero blanking,
// feeding four registered digit codes to the 7-segment indicator.
module bin_to_bcd_digits
    import indicator_pkg::*;
#(
    parameter int unsigned WIDTH         = 14,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    bin_to_bcd_digits_if.slave  bus
);
    localparam int unsigned    CNT_W     = $clog2(WIDTH + 1);
    localparam logic [BCD_W-1:0] ALL_BLANK = {NUM_DIGITS{BCD_BLANK}};

    conv_state_t       state_q, state_d;
    logic [WIDTH-1:0]  shift_q;
    logic [BCD_W-1:0]  acc_q;
    logic [BCD_W-1:0]  acc_adj;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic [BCD_W-1:0]  digits_q;
    logic              overflow_q;
    logic              out_valid_q;
    logic [BCD_W+WIDTH-1:0] shifted;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nibble   (acc_q[4*g +: 4]),
            .adjusted (acc_adj[4*g +: 4])
        );
    end

    // Carry out of the top nibble falls off here; it only occurs for overflowing values.
    assign shifted = {acc_adj, shift_q} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = CONVERT;
            CONVERT: if (cnt_q == CNT_W'(1)) state_d = BLANK;
            BLANK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            digits_q    <= ALL_BLANK;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        shift_q <= bus.value;
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(WIDTH);
                        ovf_q   <= 32'(bus.value) > MAX_DISPLAY;
                    end
                end
                CONVERT: begin
                    acc_q   <= shifted[BCD_W+WIDTH-1 -: BCD_W];
                    shift_q <= shifted[WIDTH-1:0];
                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                BLANK: begin
                    if (ovf_q) begin
                        digits_q <= ALL_BLANK;
                    end else if (BLANK_LEADING) begin
                        digits_q <= blank_leading(acc_q);
                    end else begin
                        digits_q <= acc_q;
                    end
                    overflow_q  <= ovf_q;
                    out_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.digits_bcd = digits_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Self-checking bench: two converters (leading blanking on/off) driven in lockstep,
// table vectors, hand sequences for hold/reset corners, and random values vs an arithmetic model.
module tb_bin_to_bcd_digits;
    import indicator_pkg::*;

    localparam int unsigned W = 14;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    bin_to_bcd_digits_if #(.WIDTH(W)) bus_bl ();
    bin_to_bcd_digits_if #(.WIDTH(W)) bus_nb ();

    bin_to_bcd_digits #(.WIDTH(W), .BLANK_LEADING(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_bl.slave)
    );

    bin_to_bcd_digits #(.WIDTH(W), .BLANK_LEADING(1'b0)) dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (bus_nb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          v;
        logic [15:0] exp_bl;
        logic [15:0] exp_nb;
        logic        ovf;
    } vec_t;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endfunction

    // Decimal reference built from division/modulo, independent of any shift loop.
    function automatic void model(input int v, input bit blank, output logic [15:0] d, output logic o);
        int dg [4];
        o = (v > 9999);
        if (o) begin
            d = 16'hAAAA;
            return;
        end
        dg[3] = v / 1000;
        dg[2] = (v / 100) % 10;
        dg[1] = (v / 10) % 10;
        dg[0] = v % 10;
        if (blank && v < 1000) dg[3] = 10;
        if (blank && v < 100)  dg[2] = 10;
        if (blank && v < 10)   dg[1] = 10;
        d = {dg[3][3:0], dg[2][3:0], dg[1][3:0], dg[0][3:0]};
    endfunction

    task automatic drive(input logic valid, input int v);
        bus_bl.in_valid = valid;
        bus_nb.in_valid = valid;
        bus_bl.value    = W'(v);
        bus_nb.value    = W'(v);
    endtask

    // Handshake one value into both converters and return cycles from acceptance to out_valid.
    task automatic convert(input int v, output int lat);
        int waited;
        lat    = -1;
        waited = 0;
        while (!bus_bl.in_ready && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        check("in_ready_before_send", 32'(bus_bl.in_ready), 32'd1);
        drive(1'b1, v);
        @(posedge clk); #1;
        drive(1'b0, 0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus_bl.out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int lat, input logic [15:0] e_bl,
                                input logic [15:0] e_nb, input logic e_ovf);
        check({tag, "_latency"},   32'(lat), 32'd15);
        check({tag, "_digits_bl"}, 32'(bus_bl.digits_bcd), 32'(e_bl));
        check({tag, "_digits_nb"}, 32'(bus_nb.digits_bcd), 32'(e_nb));
        check({tag, "_ovf_bl"},    32'(bus_bl.overflow), 32'(e_ovf));
        check({tag, "_ovf_nb"},    32'(bus_nb.overflow), 32'(e_ovf));
        check({tag, "_nb_valid"},  32'(bus_nb.out_valid), 32'd1);
    endtask

    initial begin
        vec_t        vecs [$];
        int          lat;
        int          cnt;
        int          v;
        logic [15:0] e_bl, e_nb;
        logic        e_o, e_o2;

        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(1'b1, 1234);

        vecs.push_back('{1234,  16'h1234, 16'h1234, 1'b0});
        vecs.push_back('{7,     16'hAAA7, 16'h0007, 1'b0});
        vecs.push_back('{0,     16'hAAA0, 16'h0000, 1'b0});
        vecs.push_back('{1005,  16'h1005, 16'h1005, 1'b0});
        vecs.push_back('{9999,  16'h9999, 16'h9999, 1'b0});
        vecs.push_back('{10000, 16'hAAAA, 16'hAAAA, 1'b1});
        vecs.push_back('{16383, 16'hAAAA, 16'hAAAA, 1'b1});
        vecs.push_back('{50,    16'hAA50, 16'h0050, 1'b0});
        vecs.push_back('{900,   16'hA900, 16'h0900, 1'b0});
        vecs.push_back('{10,    16'hAA10, 16'h0010, 1'b0});

        // in_valid held high during reset must not start a conversion
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits",    32'(bus_bl.digits_bcd), 32'hAAAA);
        check("rst_out_valid", 32'(bus_bl.out_valid),  32'd0);
        check("rst_overflow",  32'(bus_bl.overflow),   32'd0);
        drive(1'b0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready",  32'(bus_bl.in_ready),  32'd1);
        check("post_rst_out_valid", 32'(bus_bl.out_valid), 32'd0);

        foreach (vecs[i]) begin
            convert(vecs[i].v, lat);
            check_result($sformatf("vec%0d", vecs[i].v), lat, vecs[i].exp_bl, vecs[i].exp_nb, vecs[i].ovf);
            @(posedge clk); #1;
            check($sformatf("vec%0d_pulse_len", vecs[i].v), 32'(bus_bl.out_valid), 32'd0);
            check($sformatf("vec%0d_hold", vecs[i].v), 32'(bus_bl.digits_bcd), 32'(vecs[i].exp_bl));
        end

        // Held in_valid with a changed value: no recapture, second value taken in the out_valid cycle
        drive(1'b1, 321);
        @(posedge clk); #1;
        drive(1'b1, 4321);
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (!bus_bl.in_ready) cnt++;
            if (c < 14) begin
                @(posedge clk); #1;
            end
        end
        check("hold_ready_low_cycles", 32'(cnt), 32'd15);
        @(posedge clk); #1;
        check("hold_first_valid",  32'(bus_bl.out_valid),  32'd1);
        check("hold_first_digits", 32'(bus_bl.digits_bcd), 32'hA321);
        check("hold_first_ready",  32'(bus_bl.in_ready),   32'd1);
        @(posedge clk); #1;
        drive(1'b0, 0);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus_bl.out_valid) begin
                lat = c;
                break;
            end
        end
        check_result("hold_second", lat, 16'h4321, 16'h4321, 1'b0);

        // Leave overflow set, then abort a conversion with reset at CONVERT cycle 7
        convert(10000, lat);
        check_result("pre_abort_ovf", lat, 16'hAAAA, 16'hAAAA, 1'b1);
        drive(1'b1, 5678);
        @(posedge clk); #1;
        drive(1'b0, 0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_digits",    32'(bus_bl.digits_bcd), 32'hAAAA);
        check("abort_overflow",  32'(bus_bl.overflow),   32'd0);
        check("abort_out_valid", 32'(bus_bl.out_valid),  32'd0);
        check("abort_in_ready",  32'(bus_bl.in_ready),   32'd1);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus_bl.out_valid || bus_nb.out_valid) cnt++;
        end
        check("abort_no_pulse", 32'(cnt), 32'd0);
        convert(42, lat);
        check_result("after_abort_42", lat, 16'hAA42, 16'h0042, 1'b0);

        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(16383, 0));
            model(v, 1'b1, e_bl, e_o);
            model(v, 1'b0, e_nb, e_o2);
            convert(v, lat);
            check_result($sformatf("rand%0d", v), lat, e_bl, e_nb, e_o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
